// File: rtl/mult_arbiter.sv
// mult_arbiter: two-requester round-robin front end for one shared multi-cycle
// multiplier. A grant captures the winner's operands into mul_a/mul_b and holds
// mul_start until the multiplier reports mul_valid. The product is then
// registered into result and the owner gets a one-cycle done pulse. The FSM then
// waits in DRAIN for mul_valid to fall before it accepts new requests.
//
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   req0/req1         level requests, held until granted
//   a0/a1 (264b)      operand a per requester, sampled on grant
//   b0/b1 (256b)      operand b per requester, sampled on grant
//   gnt0/gnt1         one-cycle grant pulses
//   done0/done1       one-cycle completion pulses
//   result (520b)     product of the last completed operation
//   busy              high in every state except IDLE
//   mul_start         start level to the shared multiplier
//   mul_a/mul_b       operands to the multiplier
//   mul_valid         multiplier completion level
//   mul_product       multiplier product
//   timeout_err       sticky watchdog flag
//
// Optional feature: define MULT_ARB_TIMEOUT_EN to enable a RUN-state watchdog of
// TIMEOUT_CYCLES cycles. Without it, timeout_err is tied low and RUN waits
// indefinitely.

module mult_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic         req1,
  input  logic [263:0] a0,
  input  logic [263:0] a1,
  input  logic [255:0] b0,
  input  logic [255:0] b1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         done0,
  output logic         done1,
  output logic [519:0] result,
  output logic         busy,
  output logic         mul_start,
  output logic [263:0] mul_a,
  output logic [255:0] mul_b,
  input  logic         mul_valid,
  input  logic [519:0] mul_product,
  output logic         timeout_err
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t state;
  // Requester of the most recent grant; also the owner of the operation in flight.
  logic   last_gnt1;
  logic   pick1_c;

  // Requester 1 wins when it is the only requester, or when both request and
  // requester 0 was served last.
  assign pick1_c = req1 && (!req0 || !last_gnt1);

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] run_cnt;
  logic          timeout_q;
  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

  // Arbitration FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      last_gnt1 <= 1'b1;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      busy      <= 1'b0;
      mul_start <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      result    <= '0;
`ifdef MULT_ARB_TIMEOUT_EN
      run_cnt   <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            gnt0      <= !pick1_c;
            gnt1      <= pick1_c;
            mul_a     <= pick1_c ? a1 : a0;
            mul_b     <= pick1_c ? b1 : b0;
            last_gnt1 <= pick1_c;
            mul_start <= 1'b1;
            busy      <= 1'b1;
            state     <= RUN;
`ifdef MULT_ARB_TIMEOUT_EN
            run_cnt   <= '0;
`endif
          end
        end
        RUN: begin
          if (mul_valid) begin
            result    <= mul_product;
            done0     <= !last_gnt1;
            done1     <= last_gnt1;
            mul_start <= 1'b0;
            state     <= DRAIN;
          end
`ifdef MULT_ARB_TIMEOUT_EN
          // Watchdog: abandon the operation silently, no done pulse.
          else if (run_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            timeout_q <= 1'b1;
            mul_start <= 1'b0;
            state     <= DRAIN;
          end else begin
            run_cnt <= run_cnt + CW'(1);
          end
`endif
        end
        DRAIN: begin
          // Wait for the multiplier to retire its valid level before re-arbitrating.
          if (!mul_valid) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy      <= 1'b0;
          mul_start <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: directed bench for mult_arbiter with a behavioural multiplier
// that raises mul_valid 177 cycles after it first samples mul_start.

module tb_mult_arbiter;

  localparam int unsigned PW      = 520;
  localparam int unsigned MUL_LAT = 177;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0, req1;
  logic [263:0] a0, a1;
  logic [255:0] b0, b1;
  logic         gnt0, gnt1, done0, done1, busy, mul_start, mul_valid, timeout_err;
  logic [519:0] result, mul_product;
  logic [263:0] mul_a;
  logic [255:0] mul_b;
  logic         stall;
  logic [8:0]   mcnt;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int n_gnt0 = 0, n_gnt1 = 0, n_done0 = 0, n_done1 = 0, n_multi = 0;

  always #5 clk = ~clk;

  mult_arbiter dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result(result), .busy(busy), .mul_start(mul_start),
    .mul_a(mul_a), .mul_b(mul_b), .mul_valid(mul_valid),
    .mul_product(mul_product), .timeout_err(timeout_err)
  );

  // Shared multiplier model, reset from the same source as the arbiter.
  always_ff @(posedge clk) begin
    if (!rst || !mul_start) begin
      mcnt      <= '0;
      mul_valid <= 1'b0;
    end else if (!mul_valid && !stall) begin
      mcnt <= mcnt + 9'd1;
      if (mcnt == 9'(MUL_LAT)) mul_valid <= 1'b1;
    end
  end
  assign mul_product = PW'(mul_a) * PW'(mul_b);

  // Pulse counters and exclusivity monitor.
  always @(negedge clk) begin
    if (gnt0)  n_gnt0++;
    if (gnt1)  n_gnt1++;
    if (done0) n_done0++;
    if (done1) n_done1++;
    if ((gnt0 && gnt1) || (done0 && done1)) n_multi++;
  end

`ifdef MULT_ARB_TIMEOUT_EN
  logic         t_req0, t_gnt0, t_gnt1, t_done0, t_done1, t_busy, t_start, t_err;
  logic [519:0] t_result;
  logic [263:0] t_mul_a;
  logic [255:0] t_mul_b;
  int           n_tdone = 0;

  mult_arbiter #(.TIMEOUT_CYCLES(10)) dut_tmo (
    .clk(clk), .rst(rst), .req0(t_req0), .req1(1'b0),
    .a0(264'd3), .a1(264'd0), .b0(256'd5), .b1(256'd0),
    .gnt0(t_gnt0), .gnt1(t_gnt1), .done0(t_done0), .done1(t_done1),
    .result(t_result), .busy(t_busy), .mul_start(t_start),
    .mul_a(t_mul_a), .mul_b(t_mul_b), .mul_valid(1'b0),
    .mul_product(520'd0), .timeout_err(t_err)
  );

  always @(negedge clk) if (t_done0 || t_done1) n_tdone++;
`endif

  task automatic check(input string tag, input logic [519:0] got, input logic [519:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Wait (bounded) for an event; a missed event is a failed comparison.
  task automatic wait_ev(input string tag, input int sel, input int limit, output int at);
    bit hit;
    hit = 1'b0;
    at  = -1;
    for (int i = 0; i < limit && !hit; i++) begin
      step();
      case (sel)
        0:       hit = gnt0;
        1:       hit = gnt1;
        2:       hit = done0;
        3:       hit = done1;
        4:       hit = !busy;
        5:       hit = gnt0 | gnt1;
        6:       hit = done0 | done1;
        default: hit = 1'b1;
      endcase
    end
    if (hit) at = cyc;
    check(tag, PW'(hit), PW'(1));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  initial begin
    int tg, td, tmp, g0, g1, d0, d1;
    logic exp1;
    logic [519:0] exp_max;

    rst = 1'b0; req0 = 1'b0; req1 = 1'b0; stall = 1'b0;
    a0 = '0; a1 = '0; b0 = '0; b1 = '0;
`ifdef MULT_ARB_TIMEOUT_EN
    t_req0 = 1'b0;
`endif
    step();
    step();
    check("rst_ctrl", PW'({gnt0, gnt1, done0, done1, busy, mul_start, timeout_err}), PW'(0));
    check("rst_mul_a", PW'(mul_a), PW'(0));
    check("rst_result", result, PW'(0));
    rst = 1'b1;

    // Single request, 3*5.
    a0 = 264'd3; b0 = 256'd5; req0 = 1'b1;
    wait_ev("t1_gnt0", 0, 5, tg);
    req0 = 1'b0;
    check("t1_start_busy", PW'({mul_start, busy}), PW'(3));
    check("t1_mul_a", PW'(mul_a), PW'(3));
    check("t1_mul_b", PW'(mul_b), PW'(5));
    wait_ev("t1_done0", 2, 400, td);
    check("t1_latency", PW'(td - tg), PW'(179));
    check("t1_result", result, PW'(15));
    step();
    check("t1_done_pulse", PW'(done0), PW'(0));
    check("t1_result_hold", result, PW'(15));
    wait_ev("t1_idle", 4, 10, tmp);
    check("t1_counts", PW'({n_gnt0[3:0], n_gnt1[3:0], n_done0[3:0], n_done1[3:0]}), PW'(16'h1010));

    // All-ones operands: (2^264-1)*(2^256-1) = 2^520 - 2^264 - 2^256 + 1.
    exp_max = PW'(0) - (PW'(1) << 264) - (PW'(1) << 256) + PW'(1);
    a1 = '1; b1 = '1; req1 = 1'b1;
    wait_ev("t2_gnt1", 1, 5, tg);
    req1 = 1'b0;
    wait_ev("t2_done1", 3, 400, td);
    check("t2_result", result, exp_max);
    wait_ev("t2_idle", 4, 10, tmp);

    // Both requests held from reset: grants 0,1,0,1.
    do_reset();
    a0 = 264'd7; b0 = 256'd9; a1 = 264'd11; b1 = 256'd13;
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_ev("t3_gnt", 5, 10, tg);
      check("t3_order", PW'(gnt1), PW'(k % 2));
      exp1 = gnt1;
      wait_ev("t3_done", 6, 400, td);
      check("t3_done_owner", PW'(done1), PW'(exp1));
      check("t3_result", result, exp1 ? PW'(143) : PW'(63));
    end
    req0 = 1'b0; req1 = 1'b0;
    wait_ev("t3_idle", 4, 10, tmp);

    // req0 raised and withdrawn while busy, req1 held: only gnt1 pulses.
    g0 = n_gnt0; g1 = n_gnt1;
    req1 = 1'b1;
    wait_ev("t4_gnt1a", 1, 5, tg);
    repeat (5) step();
    req0 = 1'b1;
    repeat (20) step();
    req0 = 1'b0;
    wait_ev("t4_done1a", 3, 400, td);
    wait_ev("t4_gnt", 5, 10, tg);
    check("t4_regrant_is_1", PW'(gnt1), PW'(1));
    req1 = 1'b0;
    wait_ev("t4_done1b", 3, 400, td);
    wait_ev("t4_idle", 4, 10, tmp);
    check("t4_no_gnt0", PW'(n_gnt0 - g0), PW'(0));
    check("t4_gnt1_cnt", PW'(n_gnt1 - g1), PW'(2));

    // Reset 50 cycles into RUN aborts silently; priority returns to requester 0.
    a0 = 264'd3; b0 = 256'd5; req0 = 1'b1;
    wait_ev("t5_gnt0", 0, 5, tg);
    req0 = 1'b0;
    repeat (50) step();
    d0 = n_done0; d1 = n_done1;
    rst = 1'b0;
    step();
    check("t5_rst_ctrl", PW'({gnt0, gnt1, done0, done1, busy, mul_start, timeout_err, mul_valid}), PW'(0));
    check("t5_rst_ops", PW'({mul_a, mul_b}), PW'(0));
    check("t5_rst_result", result, PW'(0));
    rst = 1'b1;
    repeat (200) step();
    check("t5_no_done", PW'((n_done0 - d0) + (n_done1 - d1)), PW'(0));
    req0 = 1'b1; req1 = 1'b1;
    wait_ev("t5_regrant", 5, 5, tg);
    check("t5_prio0", PW'(gnt0), PW'(1));
    req0 = 1'b0; req1 = 1'b0;
    wait_ev("t5_done0", 2, 400, td);
    check("t5_result", result, PW'(15));
    wait_ev("t5_idle", 4, 10, tmp);

`ifdef MULT_ARB_TIMEOUT_EN
    // Watchdog instance with mul_valid stuck low and TIMEOUT_CYCLES=10.
    t_req0 = 1'b1;
    step();
    check("t6_gnt0", PW'(t_gnt0), PW'(1));
    t_req0 = 1'b0;
    repeat (9) step();
    check("t6_pre_err", PW'({t_err, t_start}), PW'(1));
    step();
    check("t6_err_set", PW'({t_err, t_start}), PW'(2));
    repeat (5) step();
    check("t6_sticky_idle", PW'({t_err, t_busy}), PW'(2));
    check("t6_no_done", PW'(n_tdone), PW'(0));
`endif

    check("one_hot", PW'(n_multi), PW'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255, giving the watchdog limit in cycles (used only with MULT_ARB_TIMEOUT_EN).
REQ-002 The block SHALL have port clk  input  1  single rising-edge clock.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-004 The block SHALL have ports req0, req1  input  1 each  requester 0/1 operation request, level, held until granted.
REQ-005 The block SHALL have ports a0, a1  input  264 each  requester operand a, sampled on grant.
REQ-006 The block SHALL have ports b0, b1  input  256 each  requester operand b, sampled on grant.
REQ-007 The block SHALL have ports gnt0, gnt1  output  1 each  one-cycle grant pulse; operands captured this cycle.
REQ-008 The block SHALL have ports done0, done1  output  1 each  one-cycle pulse; result valid for that requester.
REQ-009 The block SHALL have port result  output  520  registered product of the last completed operation.
REQ-010 The block SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 The block SHALL have port mul_start  output  1  start level to the shared multiplier.
REQ-012 The block SHALL have ports mul_a, mul_b  output  264/256  registered operands to the multiplier.
REQ-013 The block SHALL have port mul_valid  input  1  multiplier completion level.
REQ-014 The block SHALL have port mul_product  input  520  multiplier product.
REQ-015 The block SHALL have port timeout_err  output  1  sticky watchdog flag (only with MULT_ARB_TIMEOUT_EN).

Function
REQ-016 The block SHALL implement the states IDLE, RUN and DRAIN.
REQ-017 In IDLE with at least one req high, the block SHALL grant one requester, latch its a/b into mul_a/mul_b, pulse the matching gnt, set mul_start=1, and enter RUN on the next edge.
REQ-018 When both requests are high, the block SHALL grant the requester not granted most recently; the first grant after reset SHALL go to requester 0.
REQ-019 In RUN, the block SHALL hold mul_start=1 and mul_a/mul_b stable until mul_valid=1.
REQ-020 On mul_valid=1 in RUN, the block SHALL register mul_product into result, pulse done of the granted requester in the same cycle result updates, drive mul_start=0, and enter DRAIN.
REQ-021 In DRAIN, the block SHALL remain until mul_valid=0, then return to IDLE; no grant SHALL issue while in DRAIN.
REQ-022 Grant-to-done latency SHALL be the multiplier latency plus 2 cycles, which is 179 cycles for the 11x16-segment multiplier.
REQ-023 Request lines SHALL be ignored outside IDLE; deasserting a request before its grant withdraws it without side effect.
REQ-024 result SHALL hold its value until the next completion.
REQ-025 A req held high through done SHALL be re-eligible in the next IDLE, subject to round-robin order.
REQ-026 The block SHALL assert at most one gnt and at most one done per cycle.

Reset
REQ-027 On rst=0 at a clock edge, the block SHALL enter IDLE and clear gnt0, gnt1, done0, done1, busy, mul_start, mul_a, mul_b, result and timeout_err, and set round-robin priority to requester 0.
REQ-028 A reset asserted mid-operation SHALL abort the operation without emitting a done pulse.
REQ-029 The multiplier SHALL be reset from the same source so that mul_valid is 0 after reset.

Configuration
REQ-030 With MULT_ARB_TIMEOUT_EN defined, the block SHALL count cycles in RUN; if the count reaches TIMEOUT_CYCLES without mul_valid, it SHALL set timeout_err (sticky until reset), drop mul_start, enter DRAIN and emit no done.
REQ-031 Without MULT_ARB_TIMEOUT_EN, the block SHALL have no counter, tie timeout_err to 0, and wait in RUN indefinitely.

Verification
REQ-032 req0 only, a0=3, b0=5 -> gnt0 pulses once, done0 pulses 179 cycles later, result=15, busy low after DRAIN.
REQ-033 req0 and req1 both held from reset -> grants alternate in the order 0, 1, 0, 1; each done matches its granted requester.
REQ-034 a1=2^264-1, b1=2^256-1 -> result=(2^264-1)*(2^256-1) exactly, 520 bits.
REQ-035 rst=0 for one cycle 50 cycles into RUN -> all outputs 0, no done pulse, and a new request is granted normally afterwards.
REQ-036 With MULT_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=10 and mul_valid stuck at 0 -> timeout_err=1 at RUN cycle 10, mul_start=0, no done pulse.
REQ-037 req0 dropped before any grant while req1 is held -> only gnt1 pulses, and no gnt0 pulse appears.
